// File: rtl/v_x_q_mod_pi_seq.sv
// v_x_q_mod_pi_seq: for one accepted rounded SOP value v, streams
// v * (q mod p_i) mod p_i for every modulus of the selected mode, one per
// cycle. Moduli and constants live in a small register table written
// through the cfg port; reduction is a fixed-latency compare-subtract chain.
module v_x_q_mod_pi_seq #(
   parameter int V_W       = 4,
   parameter int P_W       = 30,
   parameter int NUM_MOD_0 = 7,
   parameter int NUM_MOD_1 = 6,
   parameter int MAX_MOD   = 8,
   parameter int IDX_W     = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       cfg_we,
   input  logic                       cfg_mode,
   input  logic [$clog2(MAX_MOD)-1:0] cfg_addr,
   input  logic [P_W-1:0]             cfg_p,
   input  logic [P_W-1:0]             cfg_c,
   output logic                       cfg_err,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic                       in_mode,
   input  logic [V_W-1:0]             in_v,
   output logic                       out_valid,
   output logic [P_W-1:0]             out_data,
   output logic [IDX_W-1:0]           out_idx,
   output logic                       out_last,
   output logic                       busy
);

   localparam int AW  = $clog2(MAX_MOD);
   localparam int M_W = V_W + P_W;

   typedef enum logic {
      IDLE,
      ISSUE
   } state_t;

   state_t state_q, state_d;

   logic [AW-1:0]  k_q;
   logic [AW-1:0]  k_end;
   logic [V_W-1:0] v_q;
   logic           mode_q;
   logic           accept;
   logic           issue;
   logic           issue_last;
   logic           wr_ok;

   logic [P_W-1:0] p_tab [2][MAX_MOD];
   logic [P_W-1:0] c_tab [2][MAX_MOD];

   logic             s0_valid;
   logic [P_W-1:0]   s0_p;
   logic [P_W-1:0]   s0_c;
   logic [V_W-1:0]   s0_v;
   logic [IDX_W-1:0] s0_idx;
   logic             s0_last;

   logic             s1_valid;
   logic [M_W-1:0]   s1_m;
   logic [P_W-1:0]   s1_p;
   logic [IDX_W-1:0] s1_idx;
   logic             s1_last;

   logic [V_W-1:0]   r_valid;
   logic [V_W-1:0]   r_last;
   logic [M_W-1:0]   r_m   [V_W];
   logic [P_W-1:0]   r_p   [V_W];
   logic [IDX_W-1:0] r_idx [V_W];

   // One conditional subtraction of p << sh; the chain runs sh from V_W-1 down to 0.
   function automatic logic [M_W-1:0] reduce_step(input logic [M_W-1:0] m,
                                                  input logic [P_W-1:0] p,
                                                  input int sh);
      logic [M_W-1:0] thr;
      thr = M_W'(p) << sh;
      return (m >= thr) ? (m - thr) : m;
   endfunction

   // Last slot index of the request in flight, chosen by its latched mode.
   always_comb begin
      k_end = mode_q ? AW'(NUM_MOD_1 - 1) : AW'(NUM_MOD_0 - 1);
   end

   // Sequencer next-state: accept in IDLE, then issue one slot per cycle until the last.
   always_comb begin
      state_d    = state_q;
      accept     = 1'b0;
      issue      = 1'b0;
      issue_last = 1'b0;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               accept  = 1'b1;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            issue = 1'b1;
            if (k_q == k_end) begin
               issue_last = 1'b1;
               state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Sequencer state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Request latch and slot counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         v_q    <= '0;
         mode_q <= 1'b0;
         k_q    <= '0;
      end else if (accept) begin
         v_q    <= in_v;
         mode_q <= in_mode;
         k_q    <= '0;
      end else if (issue) begin
         k_q <= k_q + 1'b1;
      end
   end

   // Handshake and activity flags derived from registered state only.
   always_comb begin
      in_ready = (state_q == IDLE);
      busy     = (state_q == ISSUE) | s0_valid | s1_valid | (|r_valid) | out_valid;
      wr_ok    = cfg_we & ~busy;
   end

   // Modulus/constant table; writes are only honoured while nothing is in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int b = 0; b < 2; b++) begin
            for (int s = 0; s < MAX_MOD; s++) begin
               p_tab[b][s] <= '0;
               c_tab[b][s] <= '0;
            end
         end
      end else if (wr_ok) begin
         p_tab[cfg_mode][cfg_addr] <= cfg_p;
         c_tab[cfg_mode][cfg_addr] <= cfg_c;
      end
   end

   // Flag a write that arrived while busy and was therefore discarded.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cfg_err <= 1'b0;
      end else begin
         cfg_err <= cfg_we & busy;
      end
   end

   // S0: register the table entry for the issued slot and its global index.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s0_valid <= 1'b0;
         s0_p     <= '0;
         s0_c     <= '0;
         s0_v     <= '0;
         s0_idx   <= '0;
         s0_last  <= 1'b0;
      end else begin
         s0_valid <= issue;
         s0_p     <= p_tab[mode_q][k_q];
         s0_c     <= c_tab[mode_q][k_q];
         s0_v     <= v_q;
         s0_idx   <= mode_q ? IDX_W'(k_q) : (IDX_W'(k_q) + IDX_W'(NUM_MOD_1));
         s0_last  <= issue_last;
      end
   end

   // S1: full-width product v * c, small enough that V_W subtract stages finish the job.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_valid <= 1'b0;
         s1_m     <= '0;
         s1_p     <= '0;
         s1_idx   <= '0;
         s1_last  <= 1'b0;
      end else begin
         s1_valid <= s0_valid;
         s1_m     <= M_W'(s0_v) * M_W'(s0_c);
         s1_p     <= s0_p;
         s1_idx   <= s0_idx;
         s1_last  <= s0_last;
      end
   end

   // Compare-subtract chain: stage s removes p << (V_W-1-s) when it fits.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_valid <= '0;
         r_last  <= '0;
         for (int s = 0; s < V_W; s++) begin
            r_m[s]   <= '0;
            r_p[s]   <= '0;
            r_idx[s] <= '0;
         end
      end else begin
         r_valid[0] <= s1_valid;
         r_last[0]  <= s1_last;
         r_m[0]     <= reduce_step(s1_m, s1_p, V_W - 1);
         r_p[0]     <= s1_p;
         r_idx[0]   <= s1_idx;
         for (int s = 1; s < V_W; s++) begin
            r_valid[s] <= r_valid[s-1];
            r_last[s]  <= r_last[s-1];
            r_m[s]     <= reduce_step(r_m[s-1], r_p[s-1], V_W - 1 - s);
            r_p[s]     <= r_p[s-1];
            r_idx[s]   <= r_idx[s-1];
         end
      end
   end

   // Output register; data and index hold between results, out_last only with a result.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_idx   <= '0;
         out_last  <= 1'b0;
      end else begin
         out_valid <= r_valid[V_W-1];
         out_last  <= r_valid[V_W-1] & r_last[V_W-1];
         if (r_valid[V_W-1]) begin
            out_data <= r_m[V_W-1][P_W-1:0];
            out_idx  <= r_idx[V_W-1];
         end
      end
   end

endmodule
